// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset level, bus widths,
// reset PC and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_HOLD = 2'b10,
        IF_DROP = 2'b11
    } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency imem and
// hands {pc, inst, valid} to if_id, honouring stall, delay-slot branch and flush.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS,
    parameter int                INST_W   = INST_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              if_stall_req_o,
    output if_state_t         dbg_state
);

    if_state_t         state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              pend_br;
    logic [ADDR_W-1:0] pend_tgt;
    logic [ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0] hold_inst;

    // imem handshake: req stays high with a stable addr until the cycle ack is
    // seen; ack with req high completes the transfer and rdata is valid then.
    assign imem_req_o     = (state == IF_WAIT) || (state == IF_DROP);
    assign imem_addr_o    = fetch_addr;
    assign if_stall_req_o = (state == IF_WAIT) && !imem_ack_i;
    assign dbg_state      = state;

    // A branch arriving with the ack beats one remembered from an earlier wait cycle.
    always_comb begin
        next_addr = fetch_addr + ADDR_W'(4);
        if (branch_flag_i) begin
            next_addr = branch_target_i;
        end else if (pend_br) begin
            next_addr = pend_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= IF_IDLE;
            fetch_addr <= RESET_PC;
            pend_br    <= 1'b0;
            pend_tgt   <= '0;
            hold_pc    <= '0;
            hold_inst  <= '0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
            if_valid_o <= 1'b0;
        end else if (flush_i) begin
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            pend_br    <= 1'b0;
            hold_pc    <= '0;
            hold_inst  <= '0;
            // An unacked request cannot be withdrawn; park the target until it completes.
            if (imem_req_o && !imem_ack_i) begin
                state    <= IF_DROP;
                pend_tgt <= new_pc_i;
            end else begin
                state      <= IF_WAIT;
                fetch_addr <= new_pc_i;
            end
        end else begin
            case (state)
                IF_IDLE: begin
                    state <= IF_WAIT;
                end
                IF_WAIT: begin
                    if (imem_ack_i) begin
                        fetch_addr <= next_addr;
                        pend_br    <= 1'b0;
                        if (stall_i) begin
                            hold_pc   <= fetch_addr;
                            hold_inst <= imem_rdata_i;
                            state     <= IF_HOLD;
                        end else begin
                            if_pc_o    <= fetch_addr;
                            if_inst_o  <= imem_rdata_i;
                            if_valid_o <= 1'b1;
                        end
                    end else begin
                        if (branch_flag_i) begin
                            pend_br  <= 1'b1;
                            pend_tgt <= branch_target_i;
                        end
                        if (!stall_i) begin
                            if_valid_o <= 1'b0;
                            if_inst_o  <= '0;
                        end
                    end
                end
                IF_HOLD: begin
                    // The buffered instruction is the delay slot; a branch only retargets the next fetch.
                    if (branch_flag_i) begin
                        fetch_addr <= branch_target_i;
                    end
                    if (!stall_i) begin
                        if_pc_o    <= hold_pc;
                        if_inst_o  <= hold_inst;
                        if_valid_o <= 1'b1;
                        state      <= IF_WAIT;
                    end
                end
                IF_DROP: begin
                    if (imem_ack_i) begin
                        fetch_addr <= pend_tgt;
                        state      <= IF_WAIT;
                    end
                end
                default: begin
                    state <= IF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: latency-programmable imem model plus scoreboards of
// expected fetch addresses and delivered instructions.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall_i = 1'b0;
    logic         branch_flag_i = 1'b0;
    logic [W-1:0] branch_target_i = '0;
    logic         flush_i = 1'b0;
    logic [W-1:0] new_pc_i = '0;
    logic         imem_req_o;
    logic [W-1:0] imem_addr_o;
    logic         imem_ack_i = 1'b0;
    logic [W-1:0] imem_rdata_i = '0;
    logic [W-1:0] if_pc_o;
    logic [W-1:0] if_inst_o;
    logic         if_valid_o;
    logic         if_stall_req_o;
    if_state_t    dbg_state;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_valid_o      (if_valid_o),
        .if_stall_req_o  (if_stall_req_o),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic stall_q = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        stall_q <= stall_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] inst_of(input logic [W-1:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    // imem model: acks after slow_lat wait cycles for slow_addr, immediately otherwise
    logic [W-1:0] slow_addr = '1;
    int           slow_lat = 0;
    int           mem_cnt = 0;

    always begin
        @(posedge clk);
        #1;
        if (!rst || !imem_req_o) begin
            imem_ack_i = 1'b0;
            mem_cnt    = 0;
        end else if (mem_cnt >= ((imem_addr_o == slow_addr) ? slow_lat : 0)) begin
            imem_ack_i = 1'b1;
            mem_cnt    = 0;
        end else begin
            imem_ack_i = 1'b0;
            mem_cnt++;
        end
        imem_rdata_i = imem_ack_i ? inst_of(imem_addr_o) : $urandom;
    end

    // scoreboard
    logic [W-1:0] exp_out[$];
    logic [W-1:0] exp_req[$];
    int           deliv_cyc[$];
    int           deliv_cnt = 0;
    int           bubble_cnt = 0;
    int           stall_req_cnt = 0;
    logic [W-1:0] mon_pc;

    always @(negedge clk) begin
        if (rst) begin
            if (imem_req_o && imem_ack_i && exp_req.size() > 0) begin
                check_eq("req_addr", imem_addr_o, exp_req.pop_front());
            end
            if (if_stall_req_o) stall_req_cnt++;
            if (!if_valid_o) begin
                check_eq("nop_inst", if_inst_o, '0);
                if (deliv_cnt > 0) bubble_cnt++;
            end else if (!stall_q && exp_out.size() > 0) begin
                mon_pc = exp_out.pop_front();
                check_eq("out_pc", if_pc_o, mon_pc);
                check_eq("out_inst", if_inst_o, inst_of(mon_pc));
                deliv_cnt++;
                deliv_cyc.push_back(cyc);
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        flush_i         = 1'b0;
        new_pc_i        = '0;
        slow_addr       = '1;
        slow_lat        = 0;
        exp_out.delete();
        exp_req.delete();
        deliv_cyc.delete();
        deliv_cnt     = 0;
        bubble_cnt    = 0;
        stall_req_cnt = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", W'(imem_req_o), 0);
        check_eq("rst_pc", if_pc_o, '0);
        check_eq("rst_inst", if_inst_o, '0);
        check_eq("rst_valid", W'(if_valid_o), 0);
        check_eq("rst_stall_req", W'(if_stall_req_o), 0);
        check_eq("rst_state", W'(dbg_state), W'(IF_IDLE));
    endtask

    task automatic push_out(input logic [W-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_out.push_back(start + W'(4 * i));
    endtask

    task automatic push_req(input logic [W-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_req.push_back(start + W'(4 * i));
    endtask

    task automatic wait_req(input logic [W-1:0] a);
        int n = 0;
        @(negedge clk);
        while (!(imem_req_o && imem_addr_o === a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!(imem_req_o && imem_addr_o === a)) check_eq("wait_req_timeout", imem_addr_o, a);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_out.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic end_scenario(input string tag);
        check_eq({tag, "_out_left"}, W'(exp_out.size()), 0);
        check_eq({tag, "_req_left"}, W'(exp_req.size()), 0);
    endtask

    int n;

    initial begin
        // zero-wait streaming from RESET_PC
        do_reset();
        push_out(32'h0, 4);
        push_req(32'h0, 4);
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_state", W'(dbg_state), W'(IF_WAIT));
        check_eq("first_req", W'(imem_req_o), 1);
        check_eq("first_addr", imem_addr_o, 32'h0);
        wait_drain(30);
        end_scenario("stream");
        check_eq("b2b_span", (deliv_cyc.size() >= 4) ? W'(deliv_cyc[3] - deliv_cyc[0]) : '1, 3);

        // three wait states on 0x10
        do_reset();
        slow_addr = 32'h10;
        slow_lat  = 3;
        push_out(32'h0, 6);
        push_req(32'h0, 6);
        rst = 1'b1;
        wait_drain(40);
        end_scenario("latency");
        check_eq("stall_req_cycles", W'(stall_req_cnt), 3);
        check_eq("bubbles_ge2", W'(bubble_cnt >= 2), 1);

        // branch with the ack for 0x24: 0x24 is the delay slot
        do_reset();
        push_out(32'h0, 10);
        push_out(32'h100, 2);
        push_req(32'h0, 10);
        push_req(32'h100, 2);
        rst = 1'b1;
        wait_req(32'h24);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        @(negedge clk);
        branch_flag_i = 1'b0;
        check_eq("br_next_addr", imem_addr_o, 32'h100);
        check_eq("br_next_req", W'(imem_req_o), 1);
        wait_drain(40);
        end_scenario("branch");

        // branch while 0x18 is still waiting: remembered until the ack
        do_reset();
        slow_addr = 32'h18;
        slow_lat  = 2;
        push_out(32'h0, 7);
        push_out(32'h200, 2);
        push_req(32'h0, 7);
        push_req(32'h200, 2);
        rst = 1'b1;
        wait_req(32'h18);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        @(negedge clk);
        branch_flag_i = 1'b0;
        check_eq("pend_addr_kept", imem_addr_o, 32'h18);
        wait_drain(40);
        end_scenario("pend_branch");

        // flush while 0x30 is unacked
        do_reset();
        slow_addr = 32'h30;
        slow_lat  = 3;
        push_out(32'h0, 12);
        push_out(32'h180, 2);
        push_req(32'h0, 13);
        push_req(32'h180, 2);
        rst = 1'b1;
        wait_req(32'h30);
        flush_i  = 1'b1;
        new_pc_i = 32'h180;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("drop_state", W'(dbg_state), W'(IF_DROP));
        check_eq("drop_valid", W'(if_valid_o), 0);
        check_eq("drop_req", W'(imem_req_o), 1);
        n = 0;
        while (dbg_state == IF_DROP && n < 10) begin
            check_eq("drop_addr", imem_addr_o, 32'h30);
            @(negedge clk);
            n++;
        end
        check_eq("drop_exit_addr", imem_addr_o, 32'h180);
        wait_drain(40);
        end_scenario("flush");

        // stall as the ack for 0x40 returns
        do_reset();
        slow_addr = 32'h40;
        slow_lat  = 2;
        push_out(32'h0, 19);
        push_req(32'h0, 19);
        rst = 1'b1;
        wait_req(32'h40);
        stall_i = 1'b1;
        n = 0;
        while (dbg_state != IF_HOLD && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_state", W'(dbg_state), W'(IF_HOLD));
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_req", W'(imem_req_o), 0);
            check_eq("hold_pc", if_pc_o, 32'h3C);
            check_eq("hold_valid", W'(if_valid_o), 1);
            @(negedge clk);
        end
        stall_i = 1'b0;
        @(negedge clk);
        check_eq("unstall_pc", if_pc_o, 32'h40);
        check_eq("unstall_valid", W'(if_valid_o), 1);
        check_eq("unstall_addr", imem_addr_o, 32'h44);
        check_eq("unstall_req", W'(imem_req_o), 1);
        wait_drain(40);
        end_scenario("stall");

        // reset in the middle of DROP
        do_reset();
        slow_addr = 32'h10;
        slow_lat  = 6;
        push_out(32'h0, 4);
        push_req(32'h0, 4);
        rst = 1'b1;
        wait_req(32'h10);
        flush_i  = 1'b1;
        new_pc_i = 32'h180;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("mid_drop_state", W'(dbg_state), W'(IF_DROP));
        rst = 1'b0;
        @(negedge clk);
        check_eq("drop_rst_req", W'(imem_req_o), 0);
        check_eq("drop_rst_pc", if_pc_o, '0);
        check_eq("drop_rst_inst", if_inst_o, '0);
        check_eq("drop_rst_valid", W'(if_valid_o), 0);
        check_eq("drop_rst_state", W'(dbg_state), W'(IF_IDLE));
        end_scenario("pre_rst");
        do_reset();
        push_out(32'h0, 2);
        push_req(32'h0, 2);
        rst = 1'b1;
        wait_drain(20);
        end_scenario("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
